// File: rtl/event_readout_sequencer.sv
// event_readout_sequencer
// Per-event controller for the drift-tube readout path (clk50 domain).
// A rising edge on trig opens the capture window. The controller then strobes
// validate_out, checks FIFO space, and either drops the event or walks the tube
// channels through the external mux into the FIFO, followed by a trailer word.
// It finishes by holding tube_clr for CLR_CYCLES.
//
// Optional build macro: EVENT_HEADER_EN
//   When defined, an 8-bit event counter is kept. Each event is then prefixed
//   with a header word {8'hFE, event_number}, and the space check reserves one
//   extra word for that header.
//
// FIFO handshake: a word is offered while the pending register is valid.
// fifo_wr_en = pending_valid & ~fifo_full, and a word counts as transferred on
// any clock edge where fifo_wr_en is high. While fifo_full is high, the pending
// word, chan_sel and pending_valid all hold their values.
module event_readout_sequencer #(
  parameter int N_CHAN        = 32,
  parameter int WINDOW_CYCLES = 257,
  parameter int CLR_CYCLES    = 11,
  parameter int FIFO_DEPTH    = 1024
) (
  input  logic        clk50,
  input  logic        rst_n,
  input  logic        trig,
  input  logic [7:0]  chan_data,
  input  logic        fifo_full,
  input  logic [9:0]  fifo_wr_count,
  output logic        busy,
  output logic        capture_en,
  output logic        validate_out,
  output logic [4:0]  chan_sel,
  output logic [15:0] fifo_din,
  output logic        fifo_wr_en,
  output logic        tube_clr,
  output logic        drop_pulse,
  output logic [15:0] drop_cnt,
  output logic [2:0]  o_dbg_state
);

`ifdef EVENT_HEADER_EN
  localparam int HDR_WORDS = 1;
`else
  localparam int HDR_WORDS = 0;
`endif

  // Words an accepted event needs: channels, trailer, and the optional header.
  localparam int          NEED_WORDS = N_CHAN + 1 + HDR_WORDS;
  localparam logic [4:0]  LAST_CH    = 5'(N_CHAN - 1);
  localparam logic [15:0] WIN_LAST   = 16'(WINDOW_CYCLES - 1);
  localparam logic [15:0] CLR_LAST   = 16'(CLR_CYCLES - 1);
  localparam logic [15:0] TRAILER_W  = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_LATCH   = 3'd2,
    S_CHECK   = 3'd3,
    S_WRITE   = 3'd4,
    S_TRAILER = 3'd5,
    S_CLEAR   = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_trig_d;
  logic [15:0] r_cnt;
  logic [4:0]  r_chan_sel;
  logic [15:0] r_pend;
  logic        r_pend_valid;
  logic        r_last_loaded;
  logic [15:0] r_drop_cnt;

  logic        w_trig_rise;
  logic [31:0] w_space;
  logic        w_space_ok;
  logic        w_accept;
  logic        w_drop;

`ifdef EVENT_HEADER_EN
  logic [7:0]  r_evt_cnt;
`endif

  // Tag for channel c: prefix chosen by c[4:3], then the low three index bits reversed.
  function automatic logic [7:0] f_tag(input logic [4:0] c);
    logic [4:0] pfx;
    case (c[4:3])
      2'd0:    pfx = 5'b11000;
      2'd1:    pfx = 5'b11001;
      2'd2:    pfx = 5'b00100;
      default: pfx = 5'b00101;
    endcase
    return {pfx, c[0], c[1], c[2]};
  endfunction

  assign w_trig_rise = trig & ~r_trig_d;
  assign w_space     = 32'(FIFO_DEPTH) - 32'(fifo_wr_count);
  assign w_space_ok  = (w_space >= 32'(NEED_WORDS));
  assign w_accept    = r_pend_valid & ~fifo_full;

  // State register.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and decoded outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_drop       = 1'b0;
    busy         = (r_state != S_IDLE);
    capture_en   = (r_state == S_CAPTURE);
    validate_out = (r_state == S_LATCH);
    tube_clr     = (r_state == S_CLEAR);
    fifo_wr_en   = w_accept;
    fifo_din     = r_pend_valid ? r_pend : 16'h0000;
    case (r_state)
      S_IDLE: begin
        if (w_trig_rise) w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (r_cnt == WIN_LAST) w_state_nxt = S_LATCH;
      end
      S_LATCH: begin
        w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (w_space_ok) begin
          w_state_nxt = S_WRITE;
        end else begin
          w_drop      = 1'b1;
          w_state_nxt = S_CLEAR;
        end
      end
      S_WRITE: begin
        if (w_accept && r_last_loaded) w_state_nxt = S_TRAILER;
      end
      S_TRAILER: begin
        if (w_accept) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        if (r_cnt == CLR_LAST) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    drop_pulse = w_drop;
  end

  assign chan_sel    = r_chan_sel;
  assign drop_cnt    = r_drop_cnt;
  assign o_dbg_state = r_state;

  // Previous trig level, used for rising-edge detection.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_trig_d <= 1'b0;
    end else begin
      r_trig_d <= trig;
    end
  end

  // Window and clear-pulse cycle counter, restarted on every state change.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 16'd0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= 16'd0;
    end else if (r_state == S_CAPTURE || r_state == S_CLEAR) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Readout pipeline: the pending word is refilled only when empty or just written.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_pend        <= 16'h0000;
      r_pend_valid  <= 1'b0;
      r_chan_sel    <= 5'd0;
      r_last_loaded <= 1'b0;
    end else begin
      case (r_state)
        S_WRITE: begin
          if (!r_pend_valid || w_accept) begin
            if (r_pend_valid && r_last_loaded) begin
              // Last channel word is going out now; queue the trailer behind it.
              r_pend        <= TRAILER_W;
              r_last_loaded <= 1'b0;
              r_chan_sel    <= 5'd0;
            end
`ifdef EVENT_HEADER_EN
            else if (!r_pend_valid) begin
              // Header goes first; chan_sel stays at 0 for the first channel.
              r_pend       <= {8'hFE, r_evt_cnt - 8'd1};
              r_pend_valid <= 1'b1;
            end
`endif
            else begin
              r_pend       <= {chan_data, f_tag(r_chan_sel)};
              r_pend_valid <= 1'b1;
              if (r_chan_sel == LAST_CH) begin
                r_last_loaded <= 1'b1;
              end else begin
                r_chan_sel <= r_chan_sel + 5'd1;
              end
            end
          end
        end
        S_TRAILER: begin
          if (w_accept) begin
            r_pend       <= 16'h0000;
            r_pend_valid <= 1'b0;
          end
        end
        default: begin
          r_pend        <= 16'h0000;
          r_pend_valid  <= 1'b0;
          r_chan_sel    <= 5'd0;
          r_last_loaded <= 1'b0;
        end
      endcase
    end
  end

  // Dropped-event counter, saturating at 0xFFFF.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= 16'd0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

`ifdef EVENT_HEADER_EN
  // Event number: counts every accepted trigger, including events later dropped.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_evt_cnt <= 8'd0;
    end else if (r_state == S_IDLE && w_trig_rise) begin
      r_evt_cnt <= r_evt_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_event_readout_sequencer.sv
// Testbench for event_readout_sequencer.
// Uses table-driven event scenarios, followed by randomized events checked
// against a word-list model.
module tb_event_readout_sequencer;

  localparam int N_CHAN = 32;
  localparam int WIN    = 257;
  localparam int CLR    = 11;
  localparam int DEPTH  = 1024;
`ifdef EVENT_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int NEED   = N_CHAN + 1 + HDR;
  localparam int BUDGET = 3000;
  localparam int TAIL   = 40;

  logic        clk50;
  logic        rst_n;
  logic        trig;
  logic [7:0]  chan_data;
  logic        fifo_full;
  logic [9:0]  fifo_wr_count;
  logic        busy;
  logic        capture_en;
  logic        validate_out;
  logic [4:0]  chan_sel;
  logic [15:0] fifo_din;
  logic        fifo_wr_en;
  logic        tube_clr;
  logic        drop_pulse;
  logic [15:0] drop_cnt;
  logic [2:0]  o_dbg_state;

  logic [7:0]  tube [N_CHAN];

  // The external channel mux: combinational, same cycle.
  assign chan_data = tube[chan_sel];

  event_readout_sequencer #(
    .N_CHAN(N_CHAN), .WINDOW_CYCLES(WIN), .CLR_CYCLES(CLR), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk50(clk50), .rst_n(rst_n), .trig(trig), .chan_data(chan_data),
    .fifo_full(fifo_full), .fifo_wr_count(fifo_wr_count), .busy(busy),
    .capture_en(capture_en), .validate_out(validate_out), .chan_sel(chan_sel),
    .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .tube_clr(tube_clr),
    .drop_pulse(drop_pulse), .drop_cnt(drop_cnt), .o_dbg_state(o_dbg_state)
  );

  // Clock and reset.
  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  typedef struct {
    int wr_count;
    int stall_at;
    int stall_len;
    int trig_mode;
    int abort_at;
    bit count_data;
    bit rand_full;
    bit exp_drop;
  } vec_t;

  int n_total;
  int n_bad;
  int evt_total;
  int drop_total;

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({busy, capture_en, validate_out, chan_sel, fifo_din, fifo_wr_en,
                tube_clr, drop_pulse, drop_cnt});
  endfunction

  // Model: tag = prefix*8 + reversed low three bits of the channel index.
  function automatic logic [7:0] model_tag(input int c);
    int pfx_tab[4];
    int rev;
    pfx_tab = '{24, 25, 4, 5};
    rev = (c % 2) * 4 + ((c / 2) % 2) * 2 + ((c / 4) % 2);
    return 8'(pfx_tab[c / 8] * 8 + rev);
  endfunction

  // Model: the expected word list for one event.
  task automatic build_exp(input bit drop);
    exp_q.delete();
    if (!drop) begin
      if (HDR != 0) exp_q.push_back({8'hFE, 8'(evt_total - 1)});
      for (int c = 0; c < N_CHAN; c++) exp_q.push_back({tube[c], model_tag(c)});
      exp_q.push_back(16'hFFFF);
    end
  endtask

  function automatic logic trig_level(input int mode, input int cyc);
    case (mode)
      0:       return cyc < 3;
      1:       return (cyc < 3) || (cyc >= 20 && cyc < 25);
      default: return cyc < 380;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    trig = 1'b0;
    fifo_full = 1'b0;
    fifo_wr_count = 10'd0;
    repeat (3) @(negedge clk50);
    #1;
    chk("reset_outs", all_outs(), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    @(negedge clk50);
    rst_n = 1'b1;
    evt_total = 0;
    drop_total = 0;
    @(negedge clk50);
  endtask

  // Driver and checker for one event.
  task automatic run_event(input vec_t v);
    int n_busy, n_cap, n_val, n_clr, n_drp, rises;
    int wr_full_bad, din_idle_bad, stall_left, fall_cyc;
    bit prev_busy, seen_busy, ended;
    int exp_busy;
    n_busy = 0; n_cap = 0; n_val = 0; n_clr = 0; n_drp = 0; rises = 0;
    wr_full_bad = 0; din_idle_bad = 0; stall_left = v.stall_len; fall_cyc = 0;
    prev_busy = 1'b0; seen_busy = 1'b0; ended = 1'b0;
    for (int c = 0; c < N_CHAN; c++) tube[c] = v.count_data ? 8'(c + 1) : 8'($urandom);
    fifo_wr_count = 10'(v.wr_count);
    evt_total++;
    if (v.exp_drop) drop_total++;
    build_exp(v.exp_drop);
    got_q.delete();
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      bit stall_now;
      trig = trig_level(v.trig_mode, cyc);
      stall_now = (v.stall_at >= 0) && (got_q.size() == v.stall_at) && (stall_left > 0);
      if (stall_now) begin
        fifo_full = 1'b1;
        stall_left--;
      end else begin
        fifo_full = v.rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      #1;
      if (busy && !prev_busy) rises++;
      prev_busy = busy;
      if (busy) begin
        n_busy++;
        seen_busy = 1'b1;
      end
      if (capture_en)   n_cap++;
      if (validate_out) n_val++;
      if (tube_clr)     n_clr++;
      if (drop_pulse)   n_drp++;
      if (fifo_wr_en && fifo_full) wr_full_bad++;
      if (!fifo_wr_en && !busy && fifo_din != 16'h0000) din_idle_bad++;
      if (stall_now) begin
        chk("stall_wr_en", 64'(fifo_wr_en), 64'd0);
        chk("stall_din", 64'(fifo_din), 64'(exp_q[v.stall_at]));
      end
      if (fifo_wr_en) got_q.push_back(fifo_din);
      if (v.abort_at >= 0 && got_q.size() == v.abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_outs", all_outs(), 64'd0);
        @(negedge clk50);
        rst_n = 1'b1;
        trig = 1'b0;
        fifo_full = 1'b0;
        evt_total = 0;
        drop_total = 0;
        @(negedge clk50);
        return;
      end
      if (seen_busy && !busy && !ended) begin
        ended = 1'b1;
        fall_cyc = cyc;
      end
      if (ended && cyc >= fall_cyc + TAIL) break;
      @(negedge clk50);
    end
    trig = 1'b0;
    fifo_full = 1'b0;
    repeat (2) @(negedge clk50);
    chk("event_done", 64'(ended), 64'd1);
    chk("busy_rises", 64'(rises), 64'd1);
    chk("capture_cycles", 64'(n_cap), 64'(WIN));
    chk("validate_cycles", 64'(n_val), 64'd1);
    chk("clr_cycles", 64'(n_clr), 64'(CLR));
    chk("drop_pulses", 64'(n_drp), 64'(v.exp_drop));
    chk("drop_cnt", 64'(drop_cnt), 64'(drop_total));
    chk("wr_while_full", 64'(wr_full_bad), 64'd0);
    chk("din_idle_nonzero", 64'(din_idle_bad), 64'd0);
    chk("word_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("word[%0d]", i), 64'(got_q[i]), 64'(exp_q[i]));
    if (!v.rand_full) begin
      exp_busy = v.exp_drop ? (WIN + 2 + CLR) : (WIN + 2 + N_CHAN + 1 + HDR + 1 + CLR + v.stall_len);
      chk("busy_cycles", 64'(n_busy), 64'(exp_busy));
    end
  endtask

  // Table of directed events, then randomized events.
  initial begin
    vec_t vecs[9];
    vec_t rv;
    n_total = 0;
    n_bad = 0;
    evt_total = 0;
    drop_total = 0;
    for (int c = 0; c < N_CHAN; c++) tube[c] = 8'd0;
    vecs[0] = '{wr_count:0, stall_at:-1, stall_len:0, trig_mode:0, abort_at:-1, count_data:1, rand_full:0, exp_drop:0};
    vecs[1] = '{wr_count:0, stall_at:10, stall_len:5, trig_mode:0, abort_at:-1, count_data:1, rand_full:0, exp_drop:0};
    vecs[2] = '{wr_count:1000, stall_at:-1, stall_len:0, trig_mode:0, abort_at:-1, count_data:1, rand_full:0, exp_drop:1};
    vecs[3] = '{wr_count:0, stall_at:-1, stall_len:0, trig_mode:1, abort_at:-1, count_data:0, rand_full:0, exp_drop:0};
    vecs[4] = '{wr_count:0, stall_at:-1, stall_len:0, trig_mode:2, abort_at:-1, count_data:0, rand_full:0, exp_drop:0};
    vecs[5] = '{wr_count:DEPTH - NEED, stall_at:-1, stall_len:0, trig_mode:0, abort_at:-1, count_data:0, rand_full:0, exp_drop:0};
    vecs[6] = '{wr_count:DEPTH - NEED + 1, stall_at:-1, stall_len:0, trig_mode:0, abort_at:-1, count_data:0, rand_full:0, exp_drop:1};
    vecs[7] = '{wr_count:0, stall_at:-1, stall_len:0, trig_mode:0, abort_at:5, count_data:1, rand_full:0, exp_drop:0};
    vecs[8] = '{wr_count:0, stall_at:-1, stall_len:0, trig_mode:0, abort_at:-1, count_data:1, rand_full:0, exp_drop:0};

    do_reset();
    for (int i = 0; i < 9; i++) run_event(vecs[i]);

    for (int i = 0; i < 8; i++) begin
      rv.wr_count   = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 800))
                                                  : int'($urandom_range(DEPTH - NEED - 3, 1023));
      rv.stall_at   = -1;
      rv.stall_len  = 0;
      rv.trig_mode  = int'($urandom_range(0, 2));
      rv.abort_at   = -1;
      rv.count_data = 1'b0;
      rv.rand_full  = 1'b1;
      rv.exp_drop   = (DEPTH - rv.wr_count) < NEED;
      run_event(rv);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
